// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, frame width, bit timing.
// With UART_RX_PARITY_EN defined the state set gains PARITY (8E1 frames).
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with extra-MSB pointers; a push while
// full is dropped unless a pop frees the slot in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [AW:0]      count,
  output logic             ovf
);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_check
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = rd_en && !empty;
  assign do_push  = wr_en && (!full || do_pop);
  assign ovf      = wr_en && !do_push;
  assign count    = wr_ptr - rd_ptr;
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only; occupancy is governed entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with synchronizer, framing/overrun flags and receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames and the parity_err_o output.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  input  logic                          rd_en_i,
  output logic [7:0]                    rd_data_o,
  output logic                          rd_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          framing_err_o,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err_o,
`endif
  output logic                          overrun_err_o
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_receiver: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
  end

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  // The start edge reaches the FSM two cycles late through the synchronizer;
  // preloading the half-bit wait by that much keeps samples centred on the line.
  localparam logic [CNT_W-1:0] SYNC_LAT  = CNT_W'(2);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  rx_state_e             state, state_nx;
  logic                  rx_p0, rx_p1;
  logic [CNT_W-1:0]      baud_cnt, baud_nx;
  logic [BIT_W-1:0]      bit_cnt, bit_nx;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  shift_en;
  logic                  push;
  logic                  frame_bad;
  logic                  fifo_ovf;
`ifdef UART_RX_PARITY_EN
  logic                  par_bad, par_bad_nx;
  logic                  par_err;
`endif

  // Stage p0/p1: two-flop synchronizer, idle-high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx_i;
      rx_p1 <= rx_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      framing_err_o <= 1'b0;
      overrun_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad       <= 1'b0;
      parity_err_o  <= 1'b0;
`endif
    end else begin
      state         <= state_nx;
      baud_cnt      <= baud_nx;
      bit_cnt       <= bit_nx;
      framing_err_o <= frame_bad;
      overrun_err_o <= fifo_ovf;
`ifdef UART_RX_PARITY_EN
      par_bad       <= par_bad_nx;
      parity_err_o  <= par_err;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift_reg <= {rx_p1, shift_reg[DATA_BITS-1:1]};
  end

  always_comb begin
    state_nx   = state;
    baud_nx    = baud_cnt;
    bit_nx     = bit_cnt;
    shift_en   = 1'b0;
    push       = 1'b0;
    frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nx = par_bad;
    par_err    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_p1) begin
          state_nx = START;
          baud_nx  = SYNC_LAT;
          bit_nx   = '0;
        end
      end
      START: begin
        if (baud_cnt >= HALF_LAST) begin
          baud_nx  = '0;
          state_nx = rx_p1 ? IDLE : DATA;
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_nx  = '0;
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else begin
            bit_nx = bit_cnt + 1'b1;
          end
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_cnt == BIT_LAST) begin
          baud_nx    = '0;
          par_bad_nx = rx_p1 ^ (^shift_reg);
          par_err    = par_bad_nx;
          state_nx   = STOP;
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_cnt == BIT_LAST) begin
          baud_nx = '0;
          if (rx_p1) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad;
`else
            push = 1'b1;
`endif
            state_nx = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nx  = WAIT_HIGH;
          end
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_p1) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        baud_nx  = '0;
        bit_nx   = '0;
      end
    endcase
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (push),
    .wr_data  (shift_reg),
    .rd_en    (rd_en_i),
    .rd_data  (rd_data_o),
    .rd_valid (rd_valid_o),
    .count    (fifo_count_o),
    .ovf      (fifo_ovf)
  );

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rx_i, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port rd_en_i, input, 1, pop request for the FIFO head.
REQ-008 SHALL have port rd_data_o, output, 8, FIFO head byte, first-word-fall-through.
REQ-009 SHALL have port rd_valid_o, output, 1, high when the FIFO is non-empty.
REQ-010 SHALL have port fifo_count_o, output, $clog2(FIFO_DEPTH)+1, current occupancy.
REQ-011 SHALL have port framing_err_o, output, 1, one-cycle pulse when a stop bit samples low.
REQ-012 SHALL have port overrun_err_o, output, 1, one-cycle pulse when a byte is dropped because the FIFO is full.

Function
REQ-013 SHALL compute CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE with integer division (868 at defaults), and SHALL fail elaboration if the result is below 4.
REQ-014 SHALL pass rx_i through a 2-flop synchronizer (reset value 1); all frame logic uses only the synchronized value.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH, plus PARITY when the macro is defined.
- IDLE: on synchronized low, go to START and clear the bit counter.
REQ-016 START SHALL wait CLKS_PER_BIT/2 cycles and then sample the line.
- Low: go to DATA.
- High: treat as a glitch, return to IDLE, push nothing, raise no flag.
REQ-017 DATA SHALL sample 8 bits LSB first, each CLKS_PER_BIT cycles after the previous sample, then go to STOP (or PARITY).
REQ-018 STOP SHALL sample CLKS_PER_BIT cycles after the last data or parity sample.
- High: push the byte to the FIFO and return to IDLE.
- Low: pulse framing_err_o, discard the byte, go to WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL stay until the synchronized line is high, then go to IDLE, so break conditions yield exactly one framing error.
REQ-020 A pushed byte SHALL make rd_valid_o high and appear on rd_data_o on the cycle after the stop-bit sample.
REQ-021 rd_en_i while empty SHALL be ignored, with no state change.
REQ-022 A push when full SHALL drop the byte, pulse overrun_err_o and leave FIFO contents unchanged.
- If rd_en_i is high in the same cycle, the push SHALL be accepted and the count stays at FIFO_DEPTH.
REQ-023 Simultaneous push and pop at non-full occupancy SHALL leave fifo_count_o unchanged and preserve order.
REQ-024 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, using an extra MSB for full/empty detection.

Reset
REQ-025 Asserting rst_n low SHALL immediately force the following, with no clock required:
- FSM to IDLE; bit and baud counters to 0; synchronizer flops to 1.
- FIFO empty: rd_valid_o=0, fifo_count_o=0.
- framing_err_o=0, overrun_err_o=0; rd_data_o=0.
REQ-026 Reset mid-frame SHALL abandon the partial byte. After release, reception SHALL resume only on the next falling edge seen while in IDLE.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined:
- A PARITY state after DATA samples one even-parity bit.
- Output parity_err_o (1 bit) SHALL pulse on mismatch and the byte SHALL be discarded; the stop bit is still checked.
REQ-028 Without UART_RX_PARITY_EN: no PARITY state, no parity_err_o port, frame is 8N1.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum, DATA_BITS=8, and a function computing CLKS_PER_BIT.
REQ-030 The FIFO SHALL be a separate sub-module uart_rx_fifo, parameterized by width and depth; the FSM and synchronizer live in uart_receiver.

Verification
REQ-031 Bench parameters SHALL be CLK_FREQ_HZ=1000000, BAUD_RATE=100000 (10 clocks per bit).
REQ-032 Send 8N1 0xA5 -> rd_valid_o rises within 96 clocks of the start edge, rd_data_o=0xA5, fifo_count_o=1.
REQ-033 Drive rx_i low for 3 clocks then high -> no push, no error flags, FSM back in IDLE.
REQ-034 Send 0x3C with the stop bit low -> framing_err_o pulses exactly once, fifo_count_o stays 0. Hold the line low for 50 more clocks -> no further pulse.
REQ-035 Send bytes 0x00..0x10 (17 bytes) with no reads -> fifo_count_o=16, one overrun_err_o pulse. Popping gives 0x00..0x0F in order.
REQ-036 Assert rst_n mid-bit-4 of 0xFF, release, then send 0x81 -> only 0x81 is received.
REQ-037 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> parity_err_o pulses and nothing is pushed. Send it with parity bit 1 -> 0x07 is received.
